// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and default byte width for the UART TX arbiter.
// No ports. Build option UART_ARB_LOCK_EN (see uart_tx_arbiter) does not affect this file.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer/transmitter bundle between byte producers and the UART TX arbiter.
// Signals: req/din(/lock) from producers, ack back to them; tx_start/tx_data to the
// transmitter, tx_done from it; grant_id/busy/err status.
// lock exists only when UART_ARB_LOCK_EN is defined.
// Modports: master = producer/transmitter side, slave = arbiter side.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = UART_DATA_W
);
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] din;
`ifdef UART_ARB_LOCK_EN
    logic [NREQ-1:0]        lock;
`endif
    logic [NREQ-1:0]        ack;
    logic                   tx_start;
    logic [DATA_W-1:0]      tx_data;
    logic                   tx_done;
    logic [IW-1:0]          grant_id;
    logic                   busy;
    logic                   err;
`ifdef UART_ARB_LOCK_EN
    modport master (output req, din, lock, tx_done, input ack, tx_start, tx_data, grant_id, busy, err);
    modport slave  (input req, din, lock, tx_done, output ack, tx_start, tx_data, grant_id, busy, err);
`else
    modport master (output req, din, tx_done, input ack, tx_start, tx_data, grant_id, busy, err);
    modport slave  (input req, din, tx_done, output ack, tx_start, tx_data, grant_id, busy, err);
`endif
endinterface

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
// Ports: i_req (request vector), i_last (previous owner), o_valid (any request), o_idx (winner).
// Search starts at i_last+1 modulo N; o_idx falls back to i_last when nothing is requested.
module rr_picker #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);
    assign o_valid = |i_req;
    // Walk from the farthest candidate to the nearest so the nearest set request wins.
    always_comb begin
        o_idx = i_last;
        for (int k = N; k >= 1; k--) begin
            if (i_req[IW'((int'(i_last) + k) % N)]) o_idx = IW'((int'(i_last) + k) % N);
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART byte transmitter among NREQ producers,
// with a completion watchdog.
// Ports: clk, rst (sync, active high), bus (uart_tx_arbiter_if.slave: req/din/lock/tx_done in,
// ack/tx_start/tx_data/grant_id/busy/err out).
// Build option UART_ARB_LOCK_EN: the owner holding lock keeps the transmitter across bytes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DATA_W  = UART_DATA_W,
    parameter int TIMEOUT = 4096
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_t            r_state, w_next;
    logic [NREQ-1:0]   r_ack;
    logic              r_start, r_err;
    logic [DATA_W-1:0] r_tx_data;
    logic [IW-1:0]     r_grant_id, w_pick, w_id;
    logic [CW-1:0]     r_cnt;
    logic              w_valid, w_load, w_err, w_tmo, w_keep;

    rr_picker #(.N(NREQ)) u_pick (
        .i_req   (bus.req),
        .i_last  (r_grant_id),
        .o_valid (w_valid),
        .o_idx   (w_pick)
    );

    assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
`ifdef UART_ARB_LOCK_EN
    assign w_keep = bus.lock[r_grant_id] && bus.req[r_grant_id];
`else
    assign w_keep = 1'b0;
`endif

    // w_load marks a grant: latch owner and byte, pulse ack/tx_start next cycle.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_id   = r_grant_id;
        w_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_load = w_valid;
                w_id   = w_pick;
                w_next = w_valid ? ISSUE : IDLE;
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                // Completion beats a simultaneous timeout; lock only applies on completion.
                w_load = bus.tx_done && w_keep;
                w_err  = !bus.tx_done && w_tmo;
                w_next = w_load ? ISSUE : (bus.tx_done || w_tmo) ? IDLE : WAIT;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ack      <= '0;
            r_start    <= 1'b0;
            r_tx_data  <= '0;
            r_grant_id <= IW'(NREQ - 1);
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_load ? NREQ'(1) << w_id : '0;
            r_start <= w_load;
            r_err   <= w_err;
            // Zero outside WAIT, so every WAIT entry starts from 0; saturating count.
            r_cnt   <= (r_state != WAIT) ? '0 : (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
            if (w_load) begin
                r_grant_id <= w_id;
                r_tx_data  <= bus.din[int'(w_id) * DATA_W +: DATA_W];
            end
        end
    end

    assign bus.ack      = r_ack;
    assign bus.tx_start = r_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = (r_state != IDLE);
    assign bus.err      = r_err;
endmodule
